// File: rtl/adder_acc_pkg.sv
// Shared types and default widths for the adder result accumulator.
package adder_acc_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int ACC_WIDTH_DEF   = 16;
    localparam int COUNT_WIDTH_DEF = 4;
    localparam int SAMPLE_WIDTH_DEF = DATA_WIDTH_DEF + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

    // A sample is the adder result with its carry on top.
    function automatic int sample_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/adder_acc_add.sv
// Accumulator adder: acc + sample with carry-out detection.
// ADDER_ACC_SATURATE_EN selects clamp-to-all-ones instead of modulo wrap.
module adder_acc_add
    import adder_acc_pkg::*;
#(
    parameter int acc_width_g = ACC_WIDTH_DEF
) (
    input  logic [acc_width_g-1:0] acc,
    input  logic [acc_width_g-1:0] sample,
    output logic [acc_width_g-1:0] acc_next,
    output logic                   overflow
);

    logic [acc_width_g:0] raw;

    assign raw      = {1'b0, acc} + {1'b0, sample};
    assign overflow = raw[acc_width_g];

`ifdef ADDER_ACC_SATURATE_EN
    assign acc_next = overflow ? '1 : raw[acc_width_g-1:0];
`else
    assign acc_next = raw[acc_width_g-1:0];
`endif

endmodule

// File: rtl/adder_result_acc.sv
// Frame accumulator for {carry, result} samples with valid/ready on both sides.
// ADDER_ACC_SATURATE_EN (see adder_acc_add) selects saturating accumulation.
//
// state | meaning
// IDLE  | waiting for the first sample of a frame
// ACC   | summing the remaining samples of the frame
// HOLD  | frame sum presented, upstream back-pressured
module adder_result_acc
    import adder_acc_pkg::*;
#(
    parameter int data_width_g  = DATA_WIDTH_DEF,
    parameter int acc_width_g   = ACC_WIDTH_DEF,
    parameter int count_width_g = COUNT_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [data_width_g-1:0]  result_in,
    input  logic                     carry_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [count_width_g-1:0] frame_len_in,
    output logic [acc_width_g-1:0]   sum_out,
    output logic [count_width_g-1:0] count_out,
    output logic                     overflow_out,
    output logic                     valid_out,
    input  logic                     ready_in
);

    localparam int sample_w = sample_width(data_width_g);

    acc_state_t state, state_nxt;

    logic [sample_w-1:0]      sample;
    logic [acc_width_g-1:0]   sample_ext;
    logic [acc_width_g-1:0]   acc_q;
    logic [acc_width_g-1:0]   acc_add;
    logic                     add_ovf;
    logic                     ovf_q;
    logic [count_width_g-1:0] count_q;
    logic [count_width_g-1:0] remain_q;
    logic [count_width_g-1:0] len_eff;
    logic                     accept;

    assign sample     = {carry_in, result_in};
    assign sample_ext = acc_width_g'(sample);
    assign len_eff    = (frame_len_in == '0) ? count_width_g'(1) : frame_len_in;
    assign accept     = valid_in & ready_out;

    adder_acc_add #(
        .acc_width_g (acc_width_g)
    ) u_add (
        .acc      (acc_q),
        .sample   (sample_ext),
        .acc_next (acc_add),
        .overflow (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_out = 1'b0;
        valid_out = 1'b0;
        case (state)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in)
                    state_nxt = (len_eff == count_width_g'(1)) ? HOLD : ACC;
            end
            ACC: begin
                ready_out = 1'b1;
                if (valid_in && remain_q == count_width_g'(1))
                    state_nxt = HOLD;
            end
            HOLD: begin
                valid_out = 1'b1;
                if (ready_in)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // remain_q is a down-counter of samples still owed; terminal count 1 ends the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            count_q  <= '0;
            remain_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    acc_q    <= sample_ext;
                    count_q  <= count_width_g'(1);
                    remain_q <= len_eff - count_width_g'(1);
                    ovf_q    <= 1'b0;
                end
                ACC: if (accept) begin
                    acc_q    <= acc_add;
                    count_q  <= count_q + count_width_g'(1);
                    remain_q <= remain_q - count_width_g'(1);
                    ovf_q    <= ovf_q | add_ovf;
                end
                HOLD: if (ready_in) begin
                    acc_q    <= '0;
                    count_q  <= '0;
                    remain_q <= '0;
                    ovf_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sum_out      = acc_q;
    assign count_out    = count_q;
    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_adder_result_acc.sv
// Directed bench for adder_result_acc: default-width instance plus a 9-bit accumulator instance.
module tb_adder_result_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  result_in = '0;
    logic        carry_in = 1'b0;
    logic        valid_in = 1'b0;
    logic [3:0]  frame_len_in = '0;
    logic        ready_in = 1'b0;

    logic        ready_out, valid_out, overflow_out;
    logic [15:0] sum_out;
    logic [3:0]  count_out;

    logic        ready9, valid9, ovf9;
    logic [8:0]  sum9;
    logic [3:0]  count9;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adder_result_acc dut (
        .clk (clk), .rst (rst), .result_in (result_in), .carry_in (carry_in),
        .valid_in (valid_in), .ready_out (ready_out), .frame_len_in (frame_len_in),
        .sum_out (sum_out), .count_out (count_out), .overflow_out (overflow_out),
        .valid_out (valid_out), .ready_in (ready_in)
    );

    adder_result_acc #(.data_width_g(8), .acc_width_g(9), .count_width_g(4)) dut9 (
        .clk (clk), .rst (rst), .result_in (result_in), .carry_in (carry_in),
        .valid_in (valid_in), .ready_out (ready9), .frame_len_in (frame_len_in),
        .sum_out (sum9), .count_out (count9), .overflow_out (ovf9),
        .valid_out (valid9), .ready_in (ready_in)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [8:0] s, input logic v);
        {carry_in, result_in} = s;
        valid_in = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        vectors++; if (sum_out !== 16'h0) begin miscompares++; $display("FAIL reset_sum: got %0h expected 0", sum_out); end
        vectors++; if (count_out !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count_out); end
        vectors++; if (overflow_out !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", overflow_out); end
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        vectors++; if (ready_out !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", ready_out); end
    endtask

    task automatic test_frame3();
        frame_len_in = 4'd3;
        ready_in = 1'b1;
        drive(9'h064, 1'b1); cyc();
        drive(9'h121, 1'b1); cyc();
        drive(9'h0FF, 1'b1); cyc();
        drive(9'h000, 1'b0);
        vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL f3_valid: got %b expected 1", valid_out); end
        vectors++; if (sum_out !== 16'h0284) begin miscompares++; $display("FAIL f3_sum: got %0h expected 284", sum_out); end
        vectors++; if (count_out !== 4'd3) begin miscompares++; $display("FAIL f3_count: got %0d expected 3", count_out); end
        vectors++; if (overflow_out !== 1'b0) begin miscompares++; $display("FAIL f3_ovf: got %b expected 0", overflow_out); end
        vectors++; if (ready_out !== 1'b0) begin miscompares++; $display("FAIL f3_ready: got %b expected 0", ready_out); end
        cyc();
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL f3_valid_drop: got %b expected 0", valid_out); end
        vectors++; if (sum_out !== 16'h0) begin miscompares++; $display("FAIL f3_sum_clear: got %0h expected 0", sum_out); end
    endtask

    task automatic test_len_zero();
        frame_len_in = 4'd0;
        ready_in = 1'b0;
        drive(9'h1FF, 1'b1); cyc();
        drive(9'h000, 1'b0);
        vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL len0_valid: got %b expected 1", valid_out); end
        vectors++; if (sum_out !== 16'h01FF) begin miscompares++; $display("FAIL len0_sum: got %0h expected 1ff", sum_out); end
        vectors++; if (count_out !== 4'd1) begin miscompares++; $display("FAIL len0_count: got %0d expected 1", count_out); end
        ready_in = 1'b1;
        cyc();
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL len0_consume: got %b expected 0", valid_out); end
    endtask

    task automatic test_overflow();
        logic [8:0] exp9;
`ifdef ADDER_ACC_SATURATE_EN
        exp9 = 9'h1FF;
`else
        exp9 = 9'h001;
`endif
        frame_len_in = 4'd2;
        ready_in = 1'b0;
        drive(9'h1FF, 1'b1); cyc();
        drive(9'h002, 1'b1); cyc();
        drive(9'h000, 1'b0);
        vectors++; if (valid9 !== 1'b1) begin miscompares++; $display("FAIL ovf9_valid: got %b expected 1", valid9); end
        vectors++; if (sum9 !== exp9) begin miscompares++; $display("FAIL ovf9_sum: got %0h expected %0h", sum9, exp9); end
        vectors++; if (ovf9 !== 1'b1) begin miscompares++; $display("FAIL ovf9_flag: got %b expected 1", ovf9); end
        vectors++; if (sum_out !== 16'h0201) begin miscompares++; $display("FAIL ovf16_sum: got %0h expected 201", sum_out); end
        vectors++; if (overflow_out !== 1'b0) begin miscompares++; $display("FAIL ovf16_flag: got %b expected 0", overflow_out); end
        ready_in = 1'b1;
        cyc();
        vectors++; if (ovf9 !== 1'b0) begin miscompares++; $display("FAIL ovf9_clear: got %b expected 0", ovf9); end
    endtask

    task automatic test_hold_backpressure();
        frame_len_in = 4'd2;
        ready_in = 1'b0;
        drive(9'h010, 1'b1); cyc();
        drive(9'h020, 1'b1); cyc();
        drive(9'h055, 1'b1);
        for (int i = 0; i < 5; i++) begin
            vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, valid_out); end
            vectors++; if (sum_out !== 16'h0030) begin miscompares++; $display("FAIL hold_sum[%0d]: got %0h expected 30", i, sum_out); end
            vectors++; if (count_out !== 4'd2) begin miscompares++; $display("FAIL hold_count[%0d]: got %0d expected 2", i, count_out); end
            vectors++; if (ready_out !== 1'b0) begin miscompares++; $display("FAIL hold_ready[%0d]: got %b expected 0", i, ready_out); end
            cyc();
        end
        ready_in = 1'b1;
        cyc();
        ready_in = 1'b0;
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL hold_exit_valid: got %b expected 0", valid_out); end
        vectors++; if (sum_out !== 16'h0) begin miscompares++; $display("FAIL hold_exit_sum: got %0h expected 0", sum_out); end
        vectors++; if (ready_out !== 1'b1) begin miscompares++; $display("FAIL hold_exit_ready: got %b expected 1", ready_out); end
        cyc();
        vectors++; if (sum_out !== 16'h0055) begin miscompares++; $display("FAIL fresh_sum: got %0h expected 55", sum_out); end
        vectors++; if (count_out !== 4'd1) begin miscompares++; $display("FAIL fresh_count: got %0d expected 1", count_out); end
        drive(9'h001, 1'b1); cyc();
        drive(9'h000, 1'b0);
        vectors++; if (sum_out !== 16'h0056) begin miscompares++; $display("FAIL fresh_total: got %0h expected 56", sum_out); end
        vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL fresh_valid: got %b expected 1", valid_out); end
        ready_in = 1'b1;
        cyc();
    endtask

    task automatic test_reset_midframe();
        frame_len_in = 4'd4;
        ready_in = 1'b1;
        drive(9'h001, 1'b1); cyc();
        drive(9'h002, 1'b1); cyc();
        drive(9'h000, 1'b0);
        vectors++; if (count_out !== 4'd2) begin miscompares++; $display("FAIL mid_count: got %0d expected 2", count_out); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        vectors++; if (sum_out !== 16'h0) begin miscompares++; $display("FAIL rst_sum: got %0h expected 0", sum_out); end
        vectors++; if (count_out !== 4'd0) begin miscompares++; $display("FAIL rst_count: got %0d expected 0", count_out); end
        vectors++; if (overflow_out !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b expected 0", overflow_out); end
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", valid_out); end
        vectors++; if (ready_out !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b expected 1", ready_out); end
        drive(9'h003, 1'b1); cyc();
        drive(9'h004, 1'b1); cyc();
        drive(9'h005, 1'b1); cyc();
        drive(9'h006, 1'b1); cyc();
        drive(9'h000, 1'b0);
        vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL rst4_valid: got %b expected 1", valid_out); end
        vectors++; if (sum_out !== 16'h0012) begin miscompares++; $display("FAIL rst4_sum: got %0h expected 12", sum_out); end
        vectors++; if (count_out !== 4'd4) begin miscompares++; $display("FAIL rst4_count: got %0d expected 4", count_out); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        frame_len_in = 4'd4;
        ready_in = 1'b1;
        drive(9'h001, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            cyc();
            exp_v = ((i % 5) == 4);
            vectors++; if (valid_out !== exp_v) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, valid_out, exp_v); end
            if (exp_v) begin
                vectors++; if (sum_out !== 16'h0004) begin miscompares++; $display("FAIL b2b_sum[%0d]: got %0h expected 4", i, sum_out); end
            end
        end
        drive(9'h000, 1'b0);
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_frame3();
        test_len_zero();
        test_overflow();
        test_hold_backpressure();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
